// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_pipe_adder
// Purpose  : Pipelined group carry-lookahead adder/subtractor. One GBIT group
//            is resolved per stage, with valid/ready flow and cout/ovf flags.
//            Define CLA_SAT_EN to saturate the sum on signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
module cla_pipe_adder #(
    parameter int NBIT = 16,
    parameter int GBIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            c_in,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] sum,
    output logic            cout,
    output logic            ovf
);
    localparam int NG = NBIT / GBIT;

    generate
        if ((GBIT < 1) || (NBIT < GBIT) || ((NBIT % GBIT) != 0)) begin : g_param_check
            $error("cla_pipe_adder: NBIT (%0d) must be a positive multiple of GBIT (%0d)", NBIT, GBIT);
        end
    endgenerate

    // Sum-of-products lookahead: every carry is a flat function of g, p and ci.
    function automatic logic [GBIT:0] f_lookahead(
        input logic [GBIT-1:0] g,
        input logic [GBIT-1:0] p,
        input logic            ci
    );
        logic [GBIT:0] c;
        logic          term;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < GBIT; i++) begin
            c[i+1] = g[i];
            term   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (term & g[j]);
                term   = term & p[j];
            end
            c[i+1] = c[i+1] | (term & ci);
        end
        return c;
    endfunction

    logic            r_out_valid;
    logic [NBIT-1:0] r_sum;
    logic            r_cout;
    logic            r_ovf;

    logic            w_adv;
    logic            w_accept;
    logic [NBIT-1:0] w_b_eff;
    logic            w_c0;

    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = rst_n & w_adv;
    assign w_accept = in_valid & w_adv;
    assign w_b_eff  = sub ? ~b : b;
    assign w_c0     = sub | c_in;

    genvar s;
    generate
        for (s = 0; s < NG; s++) begin : g_stage
            localparam int UIN = NBIT - s * GBIT;
            localparam int SW  = (s + 1) * GBIT;

            logic [UIN-1:0]  w_ua;
            logic [UIN-1:0]  w_ub;
            logic            w_ci;
            logic            w_vi;
            logic [GBIT-1:0] w_g;
            logic [GBIT-1:0] w_p;
            logic [GBIT:0]   w_cy;
            logic [GBIT-1:0] w_gsum;
            logic [SW-1:0]   w_sum;

            // Stage 0 reads the ports; later stages read the previous skew registers.
            if (s == 0) begin : g_head
                assign w_ua  = a;
                assign w_ub  = w_b_eff;
                assign w_ci  = w_c0;
                assign w_vi  = w_accept;
                assign w_sum = w_gsum;
            end else begin : g_body
                assign w_ua  = g_stage[s-1].g_skew.r_ua;
                assign w_ub  = g_stage[s-1].g_skew.r_ub;
                assign w_ci  = g_stage[s-1].g_skew.r_cy;
                assign w_vi  = g_stage[s-1].g_skew.r_vld;
                assign w_sum = {w_gsum, g_stage[s-1].g_skew.r_sum};
            end

            assign w_g    = w_ua[GBIT-1:0] & w_ub[GBIT-1:0];
            assign w_p    = w_ua[GBIT-1:0] ^ w_ub[GBIT-1:0];
            assign w_cy   = f_lookahead(w_g, w_p, w_ci);
            assign w_gsum = w_p ^ w_cy[GBIT-1:0];

            if (s < NG - 1) begin : g_skew
                logic                r_vld;
                logic                r_cy;
                logic [SW-1:0]       r_sum;
                logic [UIN-GBIT-1:0] r_ua;
                logic [UIN-GBIT-1:0] r_ub;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_vld <= 1'b0;
                        r_cy  <= 1'b0;
                        r_sum <= '0;
                        r_ua  <= '0;
                        r_ub  <= '0;
                    end else if (w_adv) begin
                        r_vld <= w_vi;
                        r_cy  <= w_cy[GBIT];
                        r_sum <= w_sum;
                        r_ua  <= w_ua[UIN-1:GBIT];
                        r_ub  <= w_ub[UIN-1:GBIT];
                    end
                end
            end else begin : g_tail
                logic            w_ovf;
                logic [NBIT-1:0] w_res;

                assign w_ovf = w_cy[GBIT] ^ w_cy[GBIT-1];
`ifdef CLA_SAT_EN
                // Overflow implies a and b_eff share a sign, so A's sign picks the clamp.
                assign w_res = !w_ovf ? w_sum :
                               (w_ua[GBIT-1] ? {1'b1, {(NBIT-1){1'b0}}}
                                             : {1'b0, {(NBIT-1){1'b1}}});
`else
                assign w_res = w_sum;
`endif

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_out_valid <= 1'b0;
                        r_sum       <= '0;
                        r_cout      <= 1'b0;
                        r_ovf       <= 1'b0;
                    end else if (w_adv) begin
                        r_out_valid <= w_vi;
                        r_sum       <= w_res;
                        r_cout      <= w_cy[GBIT];
                        r_ovf       <= w_ovf;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_pipe_adder
// Purpose  : Scoreboard bench for cla_pipe_adder (16/4 and 4/2 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;
    typedef struct packed {
        logic        cout;
        logic        ovf;
        logic [15:0] sum;
    } res_t;

`ifdef CLA_SAT_EN
    localparam logic [15:0] c_t3a_sum = 16'h7FFF;
    localparam logic [15:0] c_t3b_sum = 16'h8000;
`else
    localparam logic [15:0] c_t3a_sum = 16'h8000;
    localparam logic [15:0] c_t3b_sum = 16'h7FFF;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        in_valid, in_ready, c_in, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;
    logic        in_valid2, in_ready2, c_in2, sub2, out_valid2, out_ready2, cout2, ovf2;
    logic [3:0]  a2, b2, sum2;

    int   checks   = 0;
    int   failures = 0;
    int   rx1      = 0;
    res_t q1[$];
    res_t q2[$];

    cla_pipe_adder #(.NBIT(16), .GBIT(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    cla_pipe_adder #(.NBIT(4), .GBIT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .c_in(c_in2), .sub(sub2), .out_valid(out_valid2),
        .out_ready(out_ready2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t mk(input logic co, input logic ov, input logic [15:0] s);
        res_t r;
        r.cout = co;
        r.ovf  = ov;
        r.sum  = s;
        return r;
    endfunction

    // Behavioural n-bit add: a + b_eff + cin, carries taken from integer sums.
    function automatic res_t model(input int n, input logic [15:0] ta, input logic [15:0] tb,
                                   input logic tc, input logic ts);
        int   mask, be, ci, tot, lo;
        res_t r;
        mask   = (1 << n) - 1;
        be     = (ts ? ~int'(tb) : int'(tb)) & mask;
        ci     = ts ? 1 : int'(tc);
        tot    = (int'(ta) & mask) + be + ci;
        lo     = (int'(ta) & (mask >> 1)) + (be & (mask >> 1)) + ci;
        r.cout = tot[n];
        r.ovf  = tot[n] ^ lo[n-1];
        r.sum  = 16'(tot & mask);
`ifdef CLA_SAT_EN
        if (r.ovf) r.sum = ta[n-1] ? 16'(1 << (n - 1)) : 16'((1 << (n - 1)) - 1);
`endif
        return r;
    endfunction

    always @(negedge clk) begin
        res_t e;
        if (rst_n && out_valid && out_ready) begin
            chk("dut1_beat_expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("dut1_result", 32'({cout, ovf, sum}), 32'(e));
                rx1++;
            end
        end
    end

    always @(negedge clk) begin
        res_t e;
        if (rst_n && out_valid2 && out_ready2) begin
            chk("dut2_beat_expected", 32'(q2.size() != 0), 32'd1);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                chk("dut2_result", 32'({cout2, ovf2, 12'h000, sum2}), 32'(e));
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge with in_valid still 1.
    task automatic send1(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                         input logic ts, input res_t exp);
        bit acc;
        acc      = 1'b0;
        a        = ta;
        b        = tb;
        c_in     = tc;
        sub      = ts;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            if (in_ready) begin
                q1.push_back(exp);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        chk("dut1_accept", 32'(acc), 32'd1);
    endtask

    task automatic send_rand1();
        logic [15:0] ra, rb;
        logic        rc, rs;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        send1(ra, rb, rc, rs, model(16, ra, rb, rc, rs));
    endtask

    task automatic send2(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                         input logic ts, input res_t exp);
        bit acc;
        acc       = 1'b0;
        a2        = ta;
        b2        = tb;
        c_in2     = tc;
        sub2      = ts;
        in_valid2 = 1'b1;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            if (in_ready2) begin
                q2.push_back(exp);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        chk("dut2_accept", 32'(acc), 32'd1);
    endtask

    task automatic drain1();
        in_valid = 1'b0;
        for (int n = 0; n < 200 && q1.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk("dut1_drain", 32'(q1.size()), 32'd0);
    endtask

    // The accepting edge counts as edge 1; out_valid must first be seen after edge 4.
    task automatic latency_check(input string tag);
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk(tag, 32'(out_valid), 32'(k == 4));
            if (k < 4) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] hold_sum, va, vb;
        logic        hold_cout, hold_ovf, vc, vs;
        int          rx_before;

        rst_n      = 1'b0;
        in_valid   = 1'b0; a  = '0; b  = '0; c_in  = 1'b0; sub  = 1'b0; out_ready  = 1'b0;
        in_valid2  = 1'b0; a2 = '0; b2 = '0; c_in2 = 1'b0; sub2 = 1'b0; out_ready2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_flags", 32'({cout, ovf}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_in_ready2", 32'(in_ready2), 32'd0);
        chk("rst_out_valid2", 32'(out_valid2), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Basic add and pipeline latency
        send1(16'h0002, 16'h0003, 1'b0, 1'b0, mk(1'b0, 1'b0, 16'h0005));
        latency_check("latency_first");
        drain1();

        // Full carry chain, overflow, subtraction (c_in ignored under sub)
        send1(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(1'b1, 1'b0, 16'h0000));
        send1(16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(1'b1, 1'b0, 16'h0000));
        send1(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(1'b0, 1'b1, c_t3a_sum));
        send1(16'h8000, 16'hFFFF, 1'b0, 1'b0, mk(1'b1, 1'b1, c_t3b_sum));
        send1(16'h0005, 16'h000A, 1'b0, 1'b1, mk(1'b0, 1'b0, 16'hFFFB));
        send1(16'h000A, 16'h0005, 1'b0, 1'b1, mk(1'b1, 1'b0, 16'h0005));
        send1(16'h000A, 16'h0005, 1'b1, 1'b1, mk(1'b1, 1'b0, 16'h0005));
        drain1();

        // Eight-beat stream with a three-cycle output stall in the middle
        rx_before = rx1;
        for (int k = 0; k < 5; k++) send_rand1();
        va = 16'($urandom); vb = 16'($urandom); vc = 1'($urandom); vs = 1'($urandom);
        a = va; b = vb; c_in = vc; sub = vs; in_valid = 1'b1;
        out_ready = 1'b0;
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        hold_sum = sum; hold_cout = cout; hold_ovf = ovf;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_hold", 32'({out_valid, cout, ovf, sum}), 32'({1'b1, hold_cout, hold_ovf, hold_sum}));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send1(va, vb, vc, vs, model(16, va, vb, vc, vs));
        send_rand1();
        send_rand1();
        drain1();
        chk("stream_count", 32'(rx1 - rx_before), 32'd8);

        // Asynchronous reset with beats in flight
        send1(16'h1111, 16'h2222, 1'b0, 1'b0, mk(1'b0, 1'b0, 16'h3333));
        send1(16'h0100, 16'h0200, 1'b0, 1'b0, mk(1'b0, 1'b0, 16'h0300));
        send1(16'h4000, 16'h4000, 1'b0, 1'b0, mk(1'b0, 1'b1, c_t3a_sum));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
        q1.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("rst_no_stale", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        send1(16'h0001, 16'h0001, 1'b0, 1'b0, mk(1'b0, 1'b0, 16'h0002));
        latency_check("latency_after_rst");
        drain1();

        // Exhaustive sweep of the 4-bit / 2-group instance
        for (int i = 0; i < 1024; i++) begin
            logic [3:0] ta, tb;
            logic       tc, ts;
            ta = i[9:6];
            tb = i[5:2];
            tc = i[1];
            ts = i[0];
            send2(ta, tb, tc, ts, model(4, 16'(ta), 16'(tb), tc, ts));
        end
        in_valid2 = 1'b0;
        for (int n = 0; n < 200 && q2.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        chk("dut2_drain", 32'(q2.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
